// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter for the shared system bus, with a one-cycle release gap.
// Define BUS_ARBITER_TIMEOUT_EN to abort transactions whose target never signals ready.
module bus_arbiter #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_a_request,
  input  logic        i_a_rw,
  input  logic [31:0] i_a_address,
  input  logic [31:0] i_a_wdata,
  output logic [31:0] o_a_rdata,
  output logic        o_a_ready,
  input  logic        i_b_request,
  input  logic        i_b_rw,
  input  logic [31:0] i_b_address,
  input  logic [31:0] i_b_wdata,
  output logic [31:0] o_b_rdata,
  output logic        o_b_ready,
  output logic        o_bus_request,
  output logic        o_bus_rw,
  output logic [31:0] o_bus_address,
  output logic [31:0] o_bus_wdata,
  input  logic [31:0] i_bus_rdata,
  input  logic        i_bus_ready,
  output logic        o_timeout
);

  typedef enum logic [1:0] {StIdle, StGrantA, StGrantB, StRelease} state_e;

  state_e      state_q, state_d;
  logic        last_b_q, last_b_d;
  logic        a_ready_q, a_ready_d;
  logic        b_ready_q, b_ready_d;
  logic        timeout_q, timeout_d;
  logic [31:0] a_rdata_q, a_rdata_d;
  logic [31:0] b_rdata_q, b_rdata_d;
  logic        granted, grant_b, done, timeout_hit;

  assign grant_b = (state_q == StGrantB);
  assign granted = (state_q == StGrantA) || grant_b;
  assign done    = granted && (i_bus_ready || timeout_hit);

`ifdef BUS_ARBITER_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Cleared outside a grant, so every grant starts counting from zero.
  always_comb begin
    cnt_d = '0;
    if (granted) cnt_d = cnt_q + CntW'(1);
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign timeout_hit = (cnt_q == CntW'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= StIdle;
      last_b_q  <= 1'b1;
      a_ready_q <= 1'b0;
      b_ready_q <= 1'b0;
      timeout_q <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      last_b_q  <= last_b_d;
      a_ready_q <= a_ready_d;
      b_ready_q <= b_ready_d;
      timeout_q <= timeout_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (i_a_request && (!i_b_request || last_b_q)) state_d = StGrantA;
        else if (i_b_request)                          state_d = StGrantB;
      end
      StGrantA, StGrantB: if (done) state_d = StRelease;
      StRelease:          state_d = StIdle;
      default:            state_d = StIdle;
    endcase
  end

  // Completion bookkeeping; ready takes priority over a coinciding terminal count.
  always_comb begin
    last_b_d  = last_b_q;
    a_ready_d = 1'b0;
    b_ready_d = 1'b0;
    timeout_d = 1'b0;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    if (done) begin
      last_b_d  = grant_b;
      timeout_d = !i_bus_ready;
      if (grant_b) begin
        b_ready_d = 1'b1;
        if (!i_b_rw) b_rdata_d = i_bus_ready ? i_bus_rdata : 32'h0;
      end else begin
        a_ready_d = 1'b1;
        if (!i_a_rw) a_rdata_d = i_bus_ready ? i_bus_rdata : 32'h0;
      end
    end
  end

  always_comb begin
    o_bus_request = granted;
    o_bus_rw      = 1'b0;
    o_bus_address = '0;
    o_bus_wdata   = '0;
    if (state_q == StGrantA) begin
      o_bus_rw      = i_a_rw;
      o_bus_address = i_a_address;
      o_bus_wdata   = i_a_wdata;
    end else if (grant_b) begin
      o_bus_rw      = i_b_rw;
      o_bus_address = i_b_address;
      o_bus_wdata   = i_b_wdata;
    end
  end

  assign o_a_ready = a_ready_q;
  assign o_b_ready = b_ready_q;
  assign o_a_rdata = a_rdata_q;
  assign o_b_rdata = b_rdata_q;
  assign o_timeout = timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: master/target models drive stimulus, a monitor pops
// expected completions on every ready pulse. Honors BUS_ARBITER_TIMEOUT_EN like the design.
module tb_bus_arbiter;

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  typedef struct {
    logic        is_b;
    logic [31:0] rdata;
    logic        tmo;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        a_req, a_rw, b_req, b_rw;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic [31:0] o_a_rdata, o_b_rdata;
  logic        o_a_ready, o_b_ready;
  logic        o_bus_request, o_bus_rw;
  logic [31:0] o_bus_address, o_bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ready;
  logic        o_timeout;

  txn_t a_q[$];
  txn_t b_q[$];
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int tgt_wait = 0;
  int tgt_cnt = 0;
  int cyc = 0;
  int grant_cyc = 0;
  int fall_cyc = 0;
  bit req_prev = 1'b0;
  bit gap_chk = 1'b0;
  bit gap_armed = 1'b0;

  always #5 clk = ~clk;

  bus_arbiter #(.TIMEOUT(8)) dut (
    .i_clock       (clk),
    .i_reset       (i_reset),
    .i_a_request   (a_req),
    .i_a_rw        (a_rw),
    .i_a_address   (a_addr),
    .i_a_wdata     (a_wdata),
    .o_a_rdata     (o_a_rdata),
    .o_a_ready     (o_a_ready),
    .i_b_request   (b_req),
    .i_b_rw        (b_rw),
    .i_b_address   (b_addr),
    .i_b_wdata     (b_wdata),
    .o_b_rdata     (o_b_rdata),
    .o_b_ready     (o_b_ready),
    .o_bus_request (o_bus_request),
    .o_bus_rw      (o_bus_rw),
    .o_bus_address (o_bus_address),
    .o_bus_wdata   (o_bus_wdata),
    .i_bus_rdata   (bus_rdata),
    .i_bus_ready   (bus_ready),
    .o_timeout     (o_timeout)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Master A: drop request in the ready cycle, load the next queued transaction afterwards.
  always @(negedge clk) begin
    txn_t t;
    if (i_reset) a_req = 1'b0;
    else if (a_req && o_a_ready) a_req = 1'b0;
    else if (!a_req && !o_a_ready && a_q.size() != 0) begin
      t = a_q.pop_front();
      a_rw = t.rw; a_addr = t.addr; a_wdata = t.wdata; a_req = 1'b1;
    end
  end

  always @(negedge clk) begin
    txn_t t;
    if (i_reset) b_req = 1'b0;
    else if (b_req && o_b_ready) b_req = 1'b0;
    else if (!b_req && !o_b_ready && b_q.size() != 0) begin
      t = b_q.pop_front();
      b_rw = t.rw; b_addr = t.addr; b_wdata = t.wdata; b_req = 1'b1;
    end
  end

  // Target: ready after tgt_wait grant cycles, data = address ^ constant; 0xF... is unmapped.
  always @(negedge clk) begin
    if (o_bus_request && o_bus_address[31:28] != 4'hF) begin
      if (tgt_cnt == tgt_wait) begin
        bus_ready = 1'b1;
        bus_rdata = o_bus_address ^ 32'hDEACBEEB;
      end else begin
        bus_ready = 1'b0;
        tgt_cnt++;
      end
    end else begin
      bus_ready = 1'b0;
      tgt_cnt = 0;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!i_reset) begin
      if (o_bus_request && !req_prev) begin
        grant_cyc = cyc;
        if (gap_armed) chk("release_gap", 32'(cyc - fall_cyc), 32'd2);
        gap_armed = 1'b0;
      end
      if (!o_bus_request && req_prev && gap_chk) begin
        fall_cyc = cyc;
        gap_armed = 1'b1;
      end
      if (o_bus_request) begin
        if (exp_q.size() != 0) begin
          e = exp_q[0];
          chk("bus_rw", 32'(o_bus_rw), 32'(e.is_b ? b_rw : a_rw));
          chk("bus_address", o_bus_address, e.is_b ? b_addr : a_addr);
          chk("bus_wdata", o_bus_wdata, e.is_b ? b_wdata : a_wdata);
        end
      end else begin
        chk("idle_rw", 32'(o_bus_rw), 32'd0);
        chk("idle_address", o_bus_address, 32'd0);
        chk("idle_wdata", o_bus_wdata, 32'd0);
      end
      if (o_a_ready || o_b_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ready", 32'({o_a_ready, o_b_ready}), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("ready_master", 32'({o_a_ready, o_b_ready}), e.is_b ? 32'd1 : 32'd2);
          chk("rdata", e.is_b ? o_b_rdata : o_a_rdata, e.rdata);
          chk("timeout_flag", 32'(o_timeout), 32'(e.tmo));
          chk("latency", 32'(cyc - grant_cyc), 32'(e.lat));
        end
      end else begin
        chk("timeout_idle", 32'(o_timeout), 32'd0);
      end
    end
    req_prev = o_bus_request;
  end

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: no finish after 200000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    i_reset = 1'b1;
    a_req = 0; a_rw = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_rw = 0; b_addr = '0; b_wdata = '0;
    bus_ready = 0; bus_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bus_request", 32'(o_bus_request), 32'd0);
    chk("rst_a_ready", 32'(o_a_ready), 32'd0);
    chk("rst_b_ready", 32'(o_b_ready), 32'd0);
    chk("rst_a_rdata", o_a_rdata, 32'd0);
    chk("rst_b_rdata", o_b_rdata, 32'd0);
    chk("rst_timeout", 32'(o_timeout), 32'd0);
    i_reset = 1'b0;
    @(posedge clk); #1;

    // Single zero-wait A read.
    exp_q.push_back('{1'b0, 32'hDEADBEEF, 1'b0, 1});
    a_q.push_back('{1'b0, 32'h00010004, 32'h0});
    drain(50);
    chk("a_rdata_hold", o_a_rdata, 32'hDEADBEEF);
    chk("b_rdata_untouched", o_b_rdata, 32'd0);

    // B write with three wait cycles; B read data must stay at its reset value.
    tgt_wait = 3;
    exp_q.push_back('{1'b1, 32'h0, 1'b0, 4});
    b_q.push_back('{1'b1, 32'h50000000, 32'h12345678});
    drain(50);
    tgt_wait = 0;
    chk("a_rdata_across_b", o_a_rdata, 32'hDEADBEEF);

    // Continuous contention after a B grant: strict A,B,A,B alternation.
    gap_chk = 1'b1;
    exp_q.push_back('{1'b0, 32'hDEACBFEB, 1'b0, 1});
    exp_q.push_back('{1'b1, 32'hDEACBCEB, 1'b0, 1});
    exp_q.push_back('{1'b0, 32'hDEACBFEF, 1'b0, 1});
    exp_q.push_back('{1'b1, 32'hDEACBCEB, 1'b0, 1});
    a_q.push_back('{1'b0, 32'h00000100, 32'h0});
    a_q.push_back('{1'b0, 32'h00000104, 32'h0});
    b_q.push_back('{1'b0, 32'h00000200, 32'h0});
    b_q.push_back('{1'b1, 32'h00000300, 32'hCAFEF00D});
    drain(100);
    gap_chk = 1'b0;
    gap_armed = 1'b0;

`ifdef BUS_ARBITER_TIMEOUT_EN
    // Unmapped A read aborts 8 cycles after grant, then B is served normally.
    exp_q.push_back('{1'b0, 32'h0, 1'b1, 8});
    exp_q.push_back('{1'b1, 32'hDEACBCE3, 1'b0, 1});
    a_q.push_back('{1'b0, 32'hF0000000, 32'h0});
    b_q.push_back('{1'b0, 32'h00000208, 32'h0});
    drain(100);
`else
    // Without the timeout the unmapped read waits indefinitely; reset recovers the bus.
    a_q.push_back('{1'b0, 32'hF0000000, 32'h0});
    repeat (2000) @(posedge clk);
    #1;
    chk("stuck_bus_request", 32'(o_bus_request), 32'd1);
    chk("stuck_a_ready", 32'(o_a_ready), 32'd0);
    chk("stuck_timeout", 32'(o_timeout), 32'd0);
    i_reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    i_reset = 1'b0;
    @(posedge clk); #1;
`endif

    // Reset while B is granted with ready still pending.
    tgt_wait = 5;
    b_q.push_back('{1'b0, 32'h00000400, 32'h0});
    n = 0;
    while (!o_bus_request && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("b_granted", 32'(o_bus_request), 32'd1);
    @(posedge clk);
    #2 i_reset = 1'b1;
    #1;
    chk("mid_rst_bus_request", 32'(o_bus_request), 32'd0);
    chk("mid_rst_bus_address", o_bus_address, 32'd0);
    chk("mid_rst_b_ready", 32'(o_b_ready), 32'd0);
    chk("mid_rst_a_rdata", o_a_rdata, 32'd0);
    chk("mid_rst_b_rdata", o_b_rdata, 32'd0);
    chk("mid_rst_timeout", 32'(o_timeout), 32'd0);
    repeat (2) @(posedge clk);
    #1 i_reset = 1'b0;
    tgt_wait = 0;
    @(posedge clk); #1;

    // First tie after reset goes to A.
    exp_q.push_back('{1'b0, 32'hDEACBFEB, 1'b0, 1});
    exp_q.push_back('{1'b1, 32'hDEACBCEB, 1'b0, 1});
    a_q.push_back('{1'b0, 32'h00000100, 32'h0});
    b_q.push_back('{1'b0, 32'h00000200, 32'h0});
    drain(50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
